sdp_rd_stream: RTL and testbench

SDP_RD_STREAM -- requirements
Module: sdp_rd_stream

---
 rtl/sdp_rd_stream.sv | 140 ++++++++++++++
 tb/tb_sdp_rd_stream.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdp_rd_stream.sv
// sdp_rd_stream: turns a (base_addr, len) request into a burst of reads from a
// simple dual-port RAM (always enabled, 1-cycle latency) and presents the words
// as a valid/ready stream through a 2-entry output buffer.
module sdp_rd_stream #(
   parameter int MEM_ADDR_WIDTH = 9,
   parameter int MEM_WORD_WIDTH = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [MEM_ADDR_WIDTH-1:0] base_addr,
   input  logic [MEM_ADDR_WIDTH:0]   len,
   output logic [MEM_ADDR_WIDTH-1:0] rd_addr,
   input  logic [MEM_WORD_WIDTH-1:0] rd_data_in,
   output logic [MEM_WORD_WIDTH-1:0] m_data,
   output logic                      m_valid,
   output logic                      m_last,
   input  logic                      m_ready,
   output logic                      busy,
   output logic                      done
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   localparam logic [MEM_ADDR_WIDTH:0] LEN_ONE = 1;

   state_t                    state;
   logic [MEM_ADDR_WIDTH:0]   remaining;
   logic                      inflight;
   logic                      inflight_last;
   logic [MEM_WORD_WIDTH-1:0] buf1_data;
   logic                      buf1_last;
   logic                      buf1_valid;

   logic                      pop;
   logic                      issue;
   logic [1:0]                pending;

   // Issue decision: buffer head (m_valid) + second entry + word in flight must
   // leave room, unless the head leaves this same cycle.
   always_comb begin
      pop     = m_valid && m_ready;
      pending = 2'(m_valid) + 2'(buf1_valid) + 2'(inflight);
      issue   = (state == RUN) && (remaining != '0) && ((pending < 2'd2) || pop);
   end

   // Control FSM, read address generation and the 2-entry output buffer.
   // The buffer head is the m_data/m_valid/m_last register itself; the second
   // entry only fills when the head is occupied and not leaving.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         remaining     <= '0;
         rd_addr       <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         m_data        <= '0;
         m_valid       <= 1'b0;
         m_last        <= 1'b0;
         buf1_data     <= '0;
         buf1_last     <= 1'b0;
         buf1_valid    <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         done          <= 1'b0;
         inflight      <= issue;
         inflight_last <= issue && (remaining == LEN_ONE);

         // rd_addr already holds the word being read; advance except after the
         // final issue so the address rests on the last word read
         if (issue) begin
            remaining <= remaining - 1'b1;
            if (remaining != LEN_ONE)
               rd_addr <= rd_addr + 1'b1;
         end

         if (pop) begin
            if (buf1_valid) begin
               m_data  <= buf1_data;
               m_last  <= buf1_last;
               m_valid <= 1'b1;
               if (inflight) begin
                  buf1_data <= rd_data_in;
                  buf1_last <= inflight_last;
               end else begin
                  buf1_valid <= 1'b0;
               end
            end else if (inflight) begin
               m_data <= rd_data_in;
               m_last <= inflight_last;
            end else begin
               m_valid <= 1'b0;
               m_last  <= 1'b0;
            end
         end else if (inflight) begin
            if (!m_valid) begin
               m_data  <= rd_data_in;
               m_last  <= inflight_last;
               m_valid <= 1'b1;
            end else begin
               buf1_data  <= rd_data_in;
               buf1_last  <= inflight_last;
               buf1_valid <= 1'b1;
            end
         end

         case (state)
            IDLE: begin
               if (busy) begin
                  // done cycle of the previous burst: busy still high, start ignored
                  if (done)
                     busy <= 1'b0;
               end else if (start) begin
                  if (len != '0) begin
                     state     <= RUN;
                     busy      <= 1'b1;
                     rd_addr   <= base_addr;
                     remaining <= len;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (issue && (remaining == LEN_ONE))
                  state <= DRAIN;
            end
            DRAIN: begin
               if (pop && m_last) begin
                  state <= IDLE;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sdp_rd_stream.sv
// Testbench for sdp_rd_stream: RAM model with mem[i]=i, scoreboard of expected
// words (data, last flag, optional exact cycle) checked by a negedge monitor.
module tb_sdp_rd_stream;

   localparam int AW = 9;
   localparam int DW = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   len;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data_in;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_last;
   logic          m_ready;
   logic          busy;
   logic          done;

   sdp_rd_stream #(.MEM_ADDR_WIDTH(AW), .MEM_WORD_WIDTH(DW)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
      .rd_addr(rd_addr), .rd_data_in(rd_data_in), .m_data(m_data),
      .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // RAM model: always enabled, 1-cycle read latency
   logic [DW-1:0] mem [512];
   always @(posedge clk) rd_data_in <= mem[rd_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
      int            cyc;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   acc      = 0;
   bit   rand_ready = 0;
   bit   win_en = 0;
   logic [AW-1:0] win_base;
   int   win_acc0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int d, input logic l, input int c);
      exp_t e;
      e.data = DW'(d);
      e.last = l;
      e.cyc  = c;
      exp_q.push_back(e);
   endtask

   // ready driver: constant 1, or random 50% while rand_ready is set
   initial begin
      m_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // monitor: pops the scoreboard on each handshake and checks hold during stalls
   logic          stall_prev = 1'b0;
   logic [DW-1:0] prev_data;
   logic          prev_last;
   always @(negedge clk) begin
      exp_t e;
      logic [AW-1:0] off;
      if (!rst) begin
         if (stall_prev) begin
            check("hold_valid", 64'(m_valid), 64'd1);
            check("hold_data", m_data, prev_data);
            check("hold_last", 64'(m_last), 64'(prev_last));
         end
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_word: got data %0d last %0d, expected none (cycle %0d)",
                        m_data, m_last, cyc);
            end else begin
               e = exp_q.pop_front();
               check("word_data", m_data, e.data);
               check("word_last", 64'(m_last), 64'(e.last));
               if (e.cyc >= 0)
                  check("word_cycle", 64'(cyc), 64'(e.cyc));
            end
            acc++;
         end
         if (win_en) begin
            off = rd_addr - win_base;
            n_checks++;
            if (int'(off) > acc - win_acc0 + 2) begin
               n_fail++;
               $display("FAIL issue_ahead: got %0d issued vs %0d accepted, expected at most +2",
                        off, acc - win_acc0);
            end
         end
      end
      stall_prev = !rst && m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // start in cycle n; returns positioned in cycle n+1 after the edge
   task automatic start_burst(input int b, input int l, output int n);
      tick();
      start     = 1'b1;
      base_addr = AW'(b);
      len       = (AW+1)'(l);
      n         = cyc;
      tick();
      start     = 1'b0;
   endtask

   task automatic wait_done(input int limit, output int at);
      at = -1;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (done) begin
            at = cyc;
            return;
         end
      end
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done within %0d cycles, expected done", limit);
   endtask

   task automatic idle_check_empty(input string name);
      for (int i = 0; i < 8; i++) tick();
      check(name, 64'(exp_q.size()), 64'd0);
      check({name, "_busy"}, 64'(busy), 64'd0);
   endtask

   initial begin
      int n;
      int at;
      int t0;
      for (int i = 0; i < 512; i++) mem[i] = DW'(i);
      rst = 1'b1;
      start = 1'b0;
      base_addr = '0;
      len = '0;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid", 64'(m_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_addr", 64'(rd_addr), 64'd0);
      check("rst_data", m_data, 64'd0);
      tick();
      rst = 1'b0;

      // base 0, len 4, ready held: words in N+3..N+6, done in N+7
      start_burst(0, 4, n);
      for (int i = 0; i < 4; i++) push(i, i == 3, n + 3 + i);
      @(negedge clk);
      check("t1_addr_n1", 64'(rd_addr), 64'd0);
      check("t1_busy_n1", 64'(busy), 64'd1);
      wait_done(50, at);
      check("t1_done_cycle", 64'(at), 64'(n + 7));
      check("t1_busy_at_done", 64'(busy), 64'd1);
      @(negedge clk);
      check("t1_done_pulse", 64'(done), 64'd0);
      check("t1_busy_after", 64'(busy), 64'd0);
      check("t1_q_empty", 64'(exp_q.size()), 64'd0);

      // address wrap: 510,511,0,1
      start_burst(510, 4, n);
      push(510, 1'b0, n + 3);
      push(511, 1'b0, n + 4);
      push(0,   1'b0, n + 5);
      push(1,   1'b1, n + 6);
      @(negedge clk); check("t2_addr0", 64'(rd_addr), 64'd510);
      @(negedge clk); check("t2_addr1", 64'(rd_addr), 64'd511);
      @(negedge clk); check("t2_addr2", 64'(rd_addr), 64'd0);
      @(negedge clk); check("t2_addr3", 64'(rd_addr), 64'd1);
      @(negedge clk); check("t2_addr_hold", 64'(rd_addr), 64'd1);
      wait_done(50, at);
      check("t2_done_cycle", 64'(at), 64'(n + 7));

      // len 16 with random backpressure
      tick();
      win_base   = AW'(20);
      win_acc0   = acc;
      rand_ready = 1;
      start_burst(20, 16, n);
      win_en = 1;
      for (int i = 0; i < 16; i++) push(20 + i, i == 15, -1);
      wait_done(400, at);
      win_en     = 0;
      rand_ready = 0;
      check("t3_count", 64'(acc - win_acc0), 64'd16);
      idle_check_empty("t3_q_empty");

      // len 0: no read, done next cycle, busy stays low
      start_burst(7, 0, n);
      @(negedge clk);
      check("t4_len0_done", 64'(done), 64'd1);
      check("t4_len0_busy", 64'(busy), 64'd0);
      @(negedge clk);
      check("t4_len0_done_end", 64'(done), 64'd0);
      check("t4_len0_busy_end", 64'(busy), 64'd0);

      // start while busy is ignored
      start_burst(40, 4, n);
      for (int i = 0; i < 4; i++) push(40 + i, i == 3, n + 3 + i);
      start     = 1'b1;
      base_addr = AW'(200);
      len       = (AW+1)'(3);
      tick();
      start = 1'b0;
      wait_done(50, at);
      check("t4_busy_done_cycle", 64'(at), 64'(n + 7));
      idle_check_empty("t4_q_empty");

      // reset after the 3rd word of a len 8 burst
      start_burst(0, 8, n);
      for (int i = 0; i < 3; i++) push(i, 1'b0, n + 3 + i);
      t0 = acc;
      for (int i = 0; i < 50 && acc < t0 + 3; i++) tick();
      if (acc < t0 + 3) tick();
      check("t5_three_words", 64'(acc - t0), 64'd3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("t5_valid_after_rst", 64'(m_valid), 64'd0);
      check("t5_busy_after_rst", 64'(busy), 64'd0);
      start_burst(100, 2, n);
      push(100, 1'b0, n + 3);
      push(101, 1'b1, n + 4);
      wait_done(50, at);
      check("t5_done_cycle", 64'(at), 64'(n + 5));
      idle_check_empty("t5_q_empty");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got simulation still running, expected finish");
      $fatal(1, "watchdog");
   end

endmodule
